branch_pc_unit: RTL and testbench

Branch resolution and program-counter stage that consumes the branch comparator's `less`/`equal` flags in EX. It decides whether a branch or jump is taken and drives the comparator's signedness select. It owns the fetch PC register and issues a two-cycle squash window to IF/ID after every redirect. It also keeps saturating branch statistics counters.

---
 rtl/branch_pc_unit_pkg.sv | 19 +
 rtl/branch_pc_unit_if.sv | 46 ++++
 rtl/branch_pc_unit_cond.sv | 29 ++
 rtl/branch_pc_unit.sv | 121 ++++++++++++
 tb/tb_branch_pc_unit.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared types and constants for the branch / PC stage.
// funct3 encodings, FSM states and datapath width.
package branch_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      RUN,
      SQUASH
   } state_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// EX-side bundle of the branch / PC stage.
// master drives EX inputs, slave is the stage itself.
interface branch_pc_unit_if;
   import branch_pkg::*;

   logic            i_stall;
   logic            i_ex_valid;
   logic [XLEN-1:0] i_ex_pc;
   logic [XLEN-1:0] i_ex_imm;
   logic [XLEN-1:0] i_rs1_data;
   logic [2:0]      i_funct3;
   logic            i_is_branch;
   logic            i_is_jal;
   logic            i_is_jalr;
   logic            i_br_less;
   logic            i_br_equal;
   logic            o_br_un;
   logic [XLEN-1:0] o_pc;
   logic [XLEN-1:0] o_link;
   logic            o_taken;
   logic            o_flush;
   logic            o_misaligned;
   logic [XLEN-1:0] o_br_cnt;
   logic [XLEN-1:0] o_taken_cnt;

   modport master (
      output i_stall, i_ex_valid, i_ex_pc,
      output i_ex_imm, i_rs1_data, i_funct3,
      output i_is_branch, i_is_jal, i_is_jalr,
      output i_br_less, i_br_equal,
      input  o_br_un, o_pc, o_link, o_taken,
      input  o_flush, o_misaligned,
      input  o_br_cnt, o_taken_cnt
   );

   modport slave (
      input  i_stall, i_ex_valid, i_ex_pc,
      input  i_ex_imm, i_rs1_data, i_funct3,
      input  i_is_branch, i_is_jal, i_is_jalr,
      input  i_br_less, i_br_equal,
      output o_br_un, o_pc, o_link, o_taken,
      output o_flush, o_misaligned,
      output o_br_cnt, o_taken_cnt
   );

endinterface

// File: rtl/branch_pc_unit_cond.sv
// Branch condition decode from funct3 and comparator flags.
// Also selects comparator signedness (1 = signed).
module branch_cond
   import branch_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       less,
   input  logic       equal,
   output logic       cond,
   output logic       br_un
);

   assign br_un = ~funct3[1];

   // Map funct3 to its taken condition; 010/011 never take.
   always_comb begin
      cond = 1'b0;
      unique case (1'b1)
         (funct3 == F3_BEQ):  cond = equal;
         (funct3 == F3_BNE):  cond = ~equal;
         (funct3 == F3_BLT):  cond = less;
         (funct3 == F3_BGE):  cond = ~less;
         (funct3 == F3_BLTU): cond = less;
         (funct3 == F3_BGEU): cond = ~less;
         default:             cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch resolution, fetch PC, squash window and stats.
// Redirects open a FLUSH_CYCLES window that hides EX.
module branch_pc_unit
   import branch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
   parameter int              FLUSH_CYCLES = 2
)
(
   input  logic             i_clk,
   input  logic             i_reset,
   branch_pc_unit_if.slave  bus
);

   localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

   state_t          state_q;
   state_t          state_d;
   logic [1:0]      sq_cnt_q;
   logic [1:0]      sq_cnt_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] br_cnt_q;
   logic [XLEN-1:0] tk_cnt_q;
   logic [XLEN-1:0] target;
   logic            cond;
   logic            br_un;
   logic            live;
   logic            cond_taken;
   logic            taken;

   branch_cond u_cond (
      .funct3 (bus.i_funct3),
      .less   (bus.i_br_less),
      .equal  (bus.i_br_equal),
      .cond   (cond),
      .br_un  (br_un)
   );

   assign target = bus.i_is_jalr
                 ? ((bus.i_rs1_data + bus.i_ex_imm) & ~32'h1)
                 : (bus.i_ex_pc + bus.i_ex_imm);

   assign live = bus.i_ex_valid & ~bus.i_stall
               & (state_q == RUN);

   assign cond_taken = live & (bus.i_is_jal | bus.i_is_jalr
                     | (bus.i_is_branch & cond));

   assign taken = cond_taken & ~target[1];

   assign bus.o_taken      = taken;
   assign bus.o_misaligned = cond_taken & target[1];
   assign bus.o_br_un      = bus.i_ex_valid & br_un;
   assign bus.o_link       = bus.i_ex_valid
                           ? bus.i_ex_pc + 32'd4 : '0;
   assign bus.o_pc         = pc_q;
   assign bus.o_flush      = (state_q == SQUASH);
   assign bus.o_br_cnt     = br_cnt_q;
   assign bus.o_taken_cnt  = tk_cnt_q;

   // Fetch PC: redirect on taken, else sequential; stall holds.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc_q <= RESET_PC;
      end else if (!bus.i_stall) begin
         pc_q <= taken ? target : pc_q + 32'd4;
      end
   end

   // Squash FSM next state; stall freezes state and counter.
   always_comb begin
      state_d  = state_q;
      sq_cnt_d = sq_cnt_q;
      unique case (state_q)
         RUN: begin
            if (taken) begin
               state_d  = SQUASH;
               sq_cnt_d = FLUSH_LOAD;
            end
         end
         SQUASH: begin
            if (!bus.i_stall) begin
               if (sq_cnt_q == 2'd0) begin
                  state_d = RUN;
               end else begin
                  sq_cnt_d = sq_cnt_q - 2'd1;
               end
            end
         end
         default: begin
            state_d  = RUN;
            sq_cnt_d = 2'd0;
         end
      endcase
   end

   // Squash FSM state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= RUN;
         sq_cnt_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         sq_cnt_q <= sq_cnt_d;
      end
   end

   // Saturating counts of live branches and taken branches.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         br_cnt_q <= '0;
         tk_cnt_q <= '0;
      end else if (live & bus.i_is_branch) begin
         if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 32'd1;
         if (taken && tk_cnt_q != '1) begin
            tk_cnt_q <= tk_cnt_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: vectors, hand sequences, random
// stimulus against an operand-level reference model.
module tb_branch_pc_unit;
   import branch_pkg::*;

   localparam logic [31:0] RPC = 32'h100;
   localparam int          FC  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   branch_pc_unit_if bus ();

   branch_pc_unit #(
      .RESET_PC     (RPC),
      .FLUSH_CYCLES (FC)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      logic        valid;
      logic        stall;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [2:0]  f3;
      logic [1:0]  kind;
   } stim_t;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        exp_un;
      logic        exp_tk;
   } vec_t;

   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_BR   = 2'd1;
   localparam logic [1:0] K_JAL  = 2'd2;
   localparam logic [1:0] K_JALR = 2'd3;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_pc;
   logic [31:0] m_br;
   logic [31:0] m_tk;
   int          m_flush;

   logic        cap_taken;
   logic        cap_mis;
   logic        cap_flush;
   logic        cap_un;
   logic [31:0] cap_link;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic ref_cond(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic stim_t mk(input logic [1:0] kind,
                                input logic [31:0] pc,
                                input logic [31:0] imm,
                                input logic [31:0] rs1,
                                input logic [31:0] rs2,
                                input logic [2:0] f3,
                                input logic stall);
      stim_t s;
      s.valid = (kind != K_NONE) || (pc != 0);
      s.stall = stall;
      s.pc    = pc;
      s.imm   = imm;
      s.rs1   = rs1;
      s.rs2   = rs2;
      s.f3    = f3;
      s.kind  = kind;
      return s;
   endfunction

   function automatic stim_t idle(input logic stall);
      stim_t s;
      s = mk(K_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 3'b0, stall);
      return s;
   endfunction

   task automatic drive_cycle(input stim_t s);
      logic        sgn;
      logic        live;
      logic        ct;
      logic        tk;
      logic [31:0] tgt;
      @(negedge clk);
      sgn = ~s.f3[1];
      bus.i_stall     = s.stall;
      bus.i_ex_valid  = s.valid;
      bus.i_ex_pc     = s.pc;
      bus.i_ex_imm    = s.imm;
      bus.i_rs1_data  = s.rs1;
      bus.i_funct3    = s.f3;
      bus.i_is_branch = (s.kind == K_BR);
      bus.i_is_jal    = (s.kind == K_JAL);
      bus.i_is_jalr   = (s.kind == K_JALR);
      bus.i_br_equal  = (s.rs1 == s.rs2);
      bus.i_br_less   = sgn ? ($signed(s.rs1) < $signed(s.rs2))
                            : (s.rs1 < s.rs2);
      #1;
      tgt  = (s.kind == K_JALR) ? ((s.rs1 + s.imm) & ~32'h1)
                                : (s.pc + s.imm);
      live = s.valid && !s.stall && (m_flush == 0);
      ct   = live && ((s.kind == K_JAL) || (s.kind == K_JALR)
             || ((s.kind == K_BR) && ref_cond(s.f3, s.rs1, s.rs2)));
      tk   = ct && !tgt[1];
      cap_taken = bus.o_taken;
      cap_mis   = bus.o_misaligned;
      cap_flush = bus.o_flush;
      cap_un    = bus.o_br_un;
      cap_link  = bus.o_link;
      chk("taken", {31'b0, cap_taken}, {31'b0, tk});
      chk("misaligned", {31'b0, cap_mis}, {31'b0, ct && tgt[1]});
      chk("br_un", {31'b0, cap_un}, {31'b0, s.valid && sgn});
      chk("link", cap_link, s.valid ? s.pc + 32'd4 : 32'h0);
      chk("flush_now", {31'b0, cap_flush},
          {31'b0, m_flush != 0});
      @(posedge clk);
      if (!s.stall) begin
         m_pc = tk ? tgt : m_pc + 32'd4;
         if (m_flush > 0) m_flush--;
         else if (tk) m_flush = FC;
         if (live && s.kind == K_BR) begin
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (tk && m_tk != 32'hFFFF_FFFF) m_tk++;
         end
      end
      #1;
      chk("pc", bus.o_pc, m_pc);
      chk("flush", {31'b0, bus.o_flush}, {31'b0, m_flush != 0});
      chk("br_cnt", bus.o_br_cnt, m_br);
      chk("taken_cnt", bus.o_taken_cnt, m_tk);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      bus.i_ex_valid  = 1'b0;
      bus.i_stall     = 1'b0;
      bus.i_is_branch = 1'b0;
      bus.i_is_jal    = 1'b0;
      bus.i_is_jalr   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      m_pc    = RPC;
      m_br    = 0;
      m_tk    = 0;
      m_flush = 0;
      chk("rst_pc", bus.o_pc, RPC);
      chk("rst_flush", {31'b0, bus.o_flush}, 32'h0);
      chk("rst_br_cnt", bus.o_br_cnt, 32'h0);
      chk("rst_tk_cnt", bus.o_taken_cnt, 32'h0);
      rst = 1'b0;
   endtask

   vec_t vecs [8];

   initial begin
      logic [31:0] p;
      stim_t       s;

      vecs[0] = '{3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1};
      vecs[1] = '{3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0};
      vecs[2] = '{3'b000, 32'h5, 32'h5, 1'b1, 1'b1};
      vecs[3] = '{3'b001, 32'h5, 32'h5, 1'b1, 1'b0};
      vecs[4] = '{3'b101, 32'h8000_0000, 32'h1, 1'b1, 1'b0};
      vecs[5] = '{3'b111, 32'h8000_0000, 32'h1, 1'b0, 1'b1};
      vecs[6] = '{3'b010, 32'h3, 32'h3, 1'b0, 1'b0};
      vecs[7] = '{3'b011, 32'h0, 32'h1, 1'b0, 1'b0};

      bus.i_stall     = 1'b0;
      bus.i_ex_valid  = 1'b0;
      bus.i_ex_pc     = '0;
      bus.i_ex_imm    = '0;
      bus.i_rs1_data  = '0;
      bus.i_funct3    = '0;
      bus.i_is_branch = 1'b0;
      bus.i_is_jal    = 1'b0;
      bus.i_is_jalr   = 1'b0;
      bus.i_br_less   = 1'b0;
      bus.i_br_equal  = 1'b0;

      do_reset(2);
      for (int i = 1; i <= 3; i++) begin
         drive_cycle(idle(1'b0));
         chk("free_pc", bus.o_pc, RPC + 32'(4 * i));
      end

      for (int i = 0; i < 8; i++) begin
         s = mk(K_BR, 32'h200 + 32'(16 * i), 32'h40,
                vecs[i].rs1, vecs[i].rs2, vecs[i].f3, 1'b0);
         drive_cycle(s);
         chk("vec_taken", {31'b0, cap_taken},
             {31'b0, vecs[i].exp_tk});
         chk("vec_br_un", {31'b0, cap_un},
             {31'b0, vecs[i].exp_un});
         drive_cycle(idle(1'b0));
         drive_cycle(idle(1'b0));
         if (i == 1) begin
            chk("blt_br_cnt", bus.o_br_cnt, 32'd2);
            chk("blt_tk_cnt", bus.o_taken_cnt, 32'd1);
         end
      end

      s = mk(K_BR, 32'h40, 32'h20, 32'h7, 32'h7, 3'b000, 1'b0);
      drive_cycle(s);
      chk("beq_pc", bus.o_pc, 32'h60);
      for (int i = 0; i < 2; i++) begin
         s = mk(K_JAL, 32'h80, 32'h100, 32'h0, 32'h0, 3'b0, 1'b0);
         drive_cycle(s);
         chk("win_flush", {31'b0, cap_flush}, 32'h1);
         chk("win_jal_ignored", {31'b0, cap_taken}, 32'h0);
      end
      drive_cycle(idle(1'b0));
      chk("win_end", {31'b0, cap_flush}, 32'h0);
      chk("win_pc", bus.o_pc, 32'h6C);

      s = mk(K_JALR, 32'h300, 32'h0, 32'h1001, 32'h0, 3'b0, 1'b0);
      drive_cycle(s);
      chk("jalr_taken", {31'b0, cap_taken}, 32'h1);
      chk("jalr_link", cap_link, 32'h304);
      chk("jalr_pc", bus.o_pc, 32'h1000);
      drive_cycle(idle(1'b0));
      drive_cycle(idle(1'b0));
      p = m_pc;
      s = mk(K_JALR, 32'h310, 32'h0, 32'h1002, 32'h0, 3'b0, 1'b0);
      drive_cycle(s);
      chk("jalr_mis", {31'b0, cap_mis}, 32'h1);
      chk("jalr_mis_taken", {31'b0, cap_taken}, 32'h0);
      chk("jalr_mis_pc", bus.o_pc, p + 32'd4);

      s = mk(K_JAL, 32'h500, 32'h100, 32'h0, 32'h0, 3'b0, 1'b0);
      drive_cycle(s);
      chk("sq_jal_pc", bus.o_pc, 32'h600);
      drive_cycle(idle(1'b0));
      chk("sq_c0_flush", {31'b0, cap_flush}, 32'h1);
      p = bus.o_pc;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(idle(1'b1));
         chk("sq_stall_flush", {31'b0, cap_flush}, 32'h1);
         chk("sq_stall_pc", bus.o_pc, 32'h604);
      end
      drive_cycle(idle(1'b0));
      chk("sq_last_flush", {31'b0, cap_flush}, 32'h1);
      drive_cycle(idle(1'b0));
      chk("sq_done", {31'b0, cap_flush}, 32'h0);

      p = m_pc;
      s = mk(K_BR, 32'h700, 32'h80, 32'h1, 32'h2, 3'b001, 1'b1);
      drive_cycle(s);
      chk("bne_stall_taken", {31'b0, cap_taken}, 32'h0);
      chk("bne_stall_pc", bus.o_pc, p);
      s.stall = 1'b0;
      drive_cycle(s);
      chk("bne_rel_taken", {31'b0, cap_taken}, 32'h1);
      chk("bne_rel_pc", bus.o_pc, 32'h780);
      drive_cycle(idle(1'b0));
      drive_cycle(idle(1'b0));

      s = mk(K_JAL, 32'h800, 32'h40, 32'h0, 32'h0, 3'b0, 1'b0);
      drive_cycle(s);
      drive_cycle(idle(1'b0));
      do_reset(1);
      drive_cycle(s);
      chk("post_rst_taken", {31'b0, cap_taken}, 32'h1);
      drive_cycle(idle(1'b0));
      drive_cycle(idle(1'b0));

      dut.br_cnt_q = 32'hFFFF_FFFF;
      m_br = 32'hFFFF_FFFF;
      s = mk(K_BR, 32'h900, 32'h10, 32'h1, 32'h2, 3'b000, 1'b0);
      drive_cycle(s);
      chk("sat_br_cnt", bus.o_br_cnt, 32'hFFFF_FFFF);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset(1);
         end else begin
            s.kind  = 2'($urandom_range(0, 3));
            s.valid = ($urandom_range(0, 3) != 0);
            s.stall = ($urandom_range(0, 4) == 0);
            s.pc    = $urandom & ~32'h3;
            s.imm   = ($urandom & ~32'h3)
                    | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            s.rs1   = ($urandom_range(0, 1) == 0)
                    ? 32'($urandom_range(0, 7)) : $urandom;
            s.rs2   = ($urandom_range(0, 3) == 0)
                    ? s.rs1 : $urandom;
            s.f3    = 3'($urandom_range(0, 7));
            drive_cycle(s);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
